disp_vramrd: RTL and testbench



---
 rtl/disp_pkg.sv | 17 +
 rtl/disp_vramrd_if.sv | 29 ++
 rtl/disp_vramrd.sv | 192 +++++++++++++++++++
 tb/tb_disp_vramrd.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the display VRAM read master.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_ADDR    = 2'd2,
        ST_DATA    = 2'd3
    } state_t;

    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam int PIXEL_W = 32;
    localparam int FIFO_W  = 64;

endpackage

// File: rtl/disp_vramrd_if.sv
// AXI4 read channel plus pixel FIFO write port of the display VRAM reader.
interface disp_vramrd_if;
    import disp_pkg::*;

    logic [31:0]       ARADDR;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;
    logic [FIFO_W-1:0] RDATA;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;
    logic              FIFO_WR;
    logic [FIFO_W-1:0] FIFO_WDATA;
    logic              FIFO_AFULL;

    modport master (
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY, FIFO_WR, FIFO_WDATA,
        input  ARREADY, RDATA, RLAST, RVALID, FIFO_AFULL
    );

    modport slave (
        input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY, FIFO_WR, FIFO_WDATA,
        output ARREADY, RDATA, RLAST, RVALID, FIFO_AFULL
    );

endinterface

// File: rtl/disp_vramrd.sv
// Display VRAM read master: fetches one frame per falling VSYNC over AXI4
// and writes each read beat into the pixel FIFO one cycle later.
// Optional macro DISP_VRAMRD_STAT_EN adds STAT_CLR / FRAME_LATE / FRAME_CNT.
//
// state      | meaning
// IDLE       | display off, nothing fetched
// WAIT_VS    | display on, waiting for the frame-start VSYNC edge
// ADDR       | issuing (or waiting to issue) one burst address
// DATA       | collecting the beats of the accepted burst
module disp_vramrd
    import disp_pkg::*;
#(
    parameter int H_PIXELS    = 640,
    parameter int V_LINES     = 480,
    parameter int BURST_BEATS = 16
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        DISPON,
    input  logic [28:0] DISPADDR,
    input  logic        DSP_VSYNC_X,
`ifdef DISP_VRAMRD_STAT_EN
    input  logic        STAT_CLR,
    output logic        FRAME_LATE,
    output logic [15:0] FRAME_CNT,
`endif
    disp_vramrd_if.master bus
);

    localparam int FRAME_BURSTS = (H_PIXELS * V_LINES * (PIXEL_W / 8)) / (BURST_BEATS * (FIFO_W / 8));
    localparam int CNT_W        = $clog2(FRAME_BURSTS + 1);

    state_t            state_q, state_d;
    logic [28:0]       cur_q, cur_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              prev_vsync_q, prev_vsync_d;
    logic              pend_q, pend_d;
    logic [28:0]       pend_base_q, pend_base_d;
    logic              arvalid_q, arvalid_d;
    logic [31:0]       araddr_q, araddr_d;
    logic              fifo_wr_q, fifo_wr_d;
    logic [FIFO_W-1:0] fifo_wdata_q, fifo_wdata_d;

    logic        vs_fall;
    logic        beat;
    logic        late_set;
    logic        frame_done;
    logic [28:0] base_now;
    logic        unused_addr_lsb;

    // Bases are forced to 16-word alignment so no burst crosses 4 KB.
    assign base_now        = {DISPADDR[28:4], 4'b0000};
    assign unused_addr_lsb = ^DISPADDR[3:0];
    assign vs_fall         = !DSP_VSYNC_X && prev_vsync_q;
    assign beat            = (state_q == ST_DATA) && bus.RVALID;

    // Next-state, address/burst bookkeeping and FIFO write pipeline.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        cnt_d        = cnt_q;
        prev_vsync_d = DSP_VSYNC_X;
        pend_d       = pend_q;
        pend_base_d  = pend_base_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        fifo_wr_d    = beat;
        fifo_wdata_d = beat ? bus.RDATA : fifo_wdata_q;
        late_set     = 1'b0;
        frame_done   = 1'b0;

        // A VSYNC edge mid-frame is remembered; the restart waits for RLAST.
        if (vs_fall && (state_q == ST_ADDR || state_q == ST_DATA)) begin
            pend_d      = 1'b1;
            pend_base_d = base_now;
            late_set    = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (DISPON) state_d = ST_WAIT_VS;
            end
            ST_WAIT_VS: begin
                if (!DISPON) begin
                    state_d = ST_IDLE;
                end else if (vs_fall) begin
                    cur_d   = base_now;
                    cnt_d   = '0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (!arvalid_q) begin
                    if (!DISPON) begin
                        pend_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else if (!bus.FIFO_AFULL) begin
                        arvalid_d = 1'b1;
                        araddr_d  = {cur_q, 3'b000};
                    end
                end else if (bus.ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat && bus.RLAST) begin
                    frame_done = (cnt_q == CNT_W'(FRAME_BURSTS - 1));
                    if (pend_q || vs_fall) begin
                        pend_d = 1'b0;
                        if (DISPON) begin
                            cur_d   = vs_fall ? base_now : pend_base_q;
                            cnt_d   = '0;
                            state_d = ST_ADDR;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cur_d = cur_q + 29'(BURST_BEATS);
                        cnt_d = cnt_q + CNT_W'(1);
                        if (frame_done)   state_d = ST_WAIT_VS;
                        else if (!DISPON) state_d = ST_IDLE;
                        else              state_d = ST_ADDR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            cnt_q        <= '0;
            prev_vsync_q <= 1'b1;
            pend_q       <= 1'b0;
            pend_base_q  <= '0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            fifo_wr_q    <= 1'b0;
            fifo_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            cnt_q        <= cnt_d;
            prev_vsync_q <= prev_vsync_d;
            pend_q       <= pend_d;
            pend_base_q  <= pend_base_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_wdata_q <= fifo_wdata_d;
        end
    end

`ifdef DISP_VRAMRD_STAT_EN
    logic        late_q, late_d;
    logic [15:0] fcnt_q, fcnt_d;

    // Sticky late-frame flag (a new event wins over a same-cycle clear) and frame counter.
    always_comb begin
        late_d = late_set | (late_q & !STAT_CLR);
        fcnt_d = frame_done ? fcnt_q + 16'd1 : fcnt_q;
    end

    // Statistics registers.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            late_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            late_q <= late_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign FRAME_LATE = late_q;
    assign FRAME_CNT  = fcnt_q;
`endif

    assign bus.ARADDR     = araddr_q;
    assign bus.ARLEN      = 8'(BURST_BEATS - 1);
    assign bus.ARSIZE     = AXI_SIZE_8B;
    assign bus.ARBURST    = AXI_BURST_INCR;
    assign bus.ARVALID    = arvalid_q;
    assign bus.RREADY     = (state_q == ST_DATA);
    assign bus.FIFO_WR    = fifo_wr_q;
    assign bus.FIFO_WDATA = fifo_wdata_q;

endmodule

// File: tb/tb_disp_vramrd.sv
// Bench for disp_vramrd: AXI slave model with random timing and data, an
// expected-address queue built from frame arithmetic, and a beat scoreboard.
module tb_disp_vramrd;
    import disp_pkg::*;

    localparam int BB = 16;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        DISPON = 1'b0;
    logic [28:0] DISPADDR = '0;
    logic        DSP_VSYNC_X = 1'b1;
`ifdef DISP_VRAMRD_STAT_EN
    logic        STAT_CLR = 1'b0;
    logic        FRAME_LATE;
    logic [15:0] FRAME_CNT;
`endif

    disp_vramrd_if bus ();

    disp_vramrd #(.H_PIXELS(32), .V_LINES(2), .BURST_BEATS(BB)) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .DISPON      (DISPON),
        .DISPADDR    (DISPADDR),
        .DSP_VSYNC_X (DSP_VSYNC_X),
`ifdef DISP_VRAMRD_STAT_EN
        .STAT_CLR    (STAT_CLR),
        .FRAME_LATE  (FRAME_LATE),
        .FRAME_CNT   (FRAME_CNT),
`endif
        .bus         (bus.master)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr_q[$];
    int          fifo_cnt = 0;
    int          beat_in_burst = 0;
    bit          busy = 0;
    int          beats_left = 0;
    bit          rand_slave = 0;
    int          ar_hold = 0;
    bit          prev_beat = 0;
    logic [63:0] prev_data = '0;
    bit          prev_arv_wait = 0;
    logic [31:0] prev_araddr = '0;
    int          exp_frames = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Byte address of burst idx of a frame whose base word address is b.
    function automatic logic [31:0] exp_addr(input logic [28:0] b, input int idx);
        logic [31:0] byte_base;
        byte_base = {b, 3'b000} & 32'hFFFF_FF80;
        return byte_base + 32'(idx * BB * 8);
    endfunction

    // AXI slave model + output scoreboard, all on the falling edge.
    initial begin
        bus.ARREADY = 1'b0;
        bus.RVALID = 1'b0;
        bus.RLAST = 1'b0;
        bus.RDATA = '0;
        bus.FIFO_AFULL = 1'b0;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                busy = 0; prev_beat = 0; prev_arv_wait = 0;
                bus.RVALID = 1'b0; bus.RLAST = 1'b0; bus.ARREADY = 1'b0;
            end else begin
                if (prev_beat || bus.FIFO_WR) begin
                    chk("fifo_wr", bus.FIFO_WR, prev_beat);
                    if (prev_beat) chk("fifo_wdata", bus.FIFO_WDATA, prev_data);
                end
                if (bus.FIFO_WR) fifo_cnt++;
                if (prev_arv_wait) begin
                    chk("arvalid_hold", bus.ARVALID, 1'b1);
                    chk("araddr_hold", bus.ARADDR, prev_araddr);
                end
                chk("single_outstanding", busy & bus.ARVALID, 1'b0);
                prev_beat = 0;
                if (busy && bus.RREADY) begin
                    bus.RVALID = rand_slave ? ($urandom_range(0, 3) != 0) : 1'b1;
                    bus.RDATA = {$urandom, $urandom};
                    bus.RLAST = (beats_left == 1);
                end else begin
                    bus.RVALID = 1'b0;
                    bus.RLAST = 1'b0;
                end
                if (bus.RVALID) begin
                    prev_beat = 1; prev_data = bus.RDATA;
                    beats_left--; beat_in_burst++;
                    if (beats_left == 0) busy = 0;
                end
                if (ar_hold > 0 && bus.ARVALID) begin
                    bus.ARREADY = 1'b0;
                    ar_hold--;
                end else begin
                    bus.ARREADY = rand_slave ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (bus.ARVALID && bus.ARREADY) begin
                    if (exp_addr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_ar: got ARADDR %08h, expected no request", bus.ARADDR);
                    end else begin
                        chk("araddr", bus.ARADDR, exp_addr_q.pop_front());
                    end
                    chk("arlen", bus.ARLEN, 8'd15);
                    chk("arsize", bus.ARSIZE, 3'b011);
                    chk("arburst", bus.ARBURST, 2'b01);
                    busy = 1; beats_left = BB; beat_in_burst = 0;
                    prev_arv_wait = 0;
                end else begin
                    prev_arv_wait = bus.ARVALID;
                end
                prev_araddr = bus.ARADDR;
            end
        end
    end

    task automatic vs_pulse();
        @(negedge ACLK);
        DSP_VSYNC_X = 1'b0;
        repeat (2) @(negedge ACLK);
        DSP_VSYNC_X = 1'b1;
    endtask

    task automatic wait_done(input bit toggle_afull);
        int n = 0;
        while ((exp_addr_q.size() != 0 || busy) && n < 3000) begin
            @(negedge ACLK);
            bus.FIFO_AFULL = toggle_afull ? ($urandom_range(0, 3) == 0) : 1'b0;
            n++;
        end
        bus.FIFO_AFULL = 1'b0;
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL wait_done: timeout with %0d addresses outstanding", exp_addr_q.size());
        end
        repeat (4) @(negedge ACLK);
    endtask

    task automatic wait_beats(input int nb);
        int n = 0;
        while (!(exp_addr_q.size() <= 2 && busy && beat_in_burst >= nb) && n < 500) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL wait_beats: timeout waiting for beat %0d", nb);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int bad;
        logic [28:0] rb;

        // Reset values
        repeat (3) @(negedge ACLK);
        chk("rst_arvalid", bus.ARVALID, 1'b0);
        chk("rst_rready", bus.RREADY, 1'b0);
        chk("rst_fifo_wr", bus.FIFO_WR, 1'b0);
        chk("rst_fifo_wdata", bus.FIFO_WDATA, 64'h0);
        chk("rst_araddr", bus.ARADDR, 32'h0);
        chk("rst_state", dut.state_q, ST_IDLE);
        ARESETN = 1'b1;

        // Basic frame, zero-latency slave
        DISPON = 1'b1; DISPADDR = 29'h0200_0000;
        repeat (3) @(negedge ACLK);
        chk("t1_state_waitvs", dut.state_q, ST_WAIT_VS);
        exp_addr_q.push_back(32'h1000_0000);
        exp_addr_q.push_back(32'h1000_0080);
        f0 = fifo_cnt;
        vs_pulse();
        wait_done(0);
        chk("t1_fifo_cnt", 32'(fifo_cnt - f0), 32'd32);
        chk("t1_state_end", dut.state_q, ST_WAIT_VS);
        exp_frames++;

        // Unaligned base gets masked
        rand_slave = 1;
        DISPADDR = 29'h0200_0005;
        exp_addr_q.push_back(32'h1000_0000);
        exp_addr_q.push_back(32'h1000_0080);
        f0 = fifo_cnt;
        vs_pulse();
        wait_done(0);
        chk("t2_fifo_cnt", 32'(fifo_cnt - f0), 32'd32);
        exp_frames++;

        // FIFO almost full holds off the address phase
        rand_slave = 0;
        DISPADDR = 29'h0200_0000;
        exp_addr_q.push_back(32'h1000_0000);
        exp_addr_q.push_back(32'h1000_0080);
        @(negedge ACLK);
        bus.FIFO_AFULL = 1'b1;
        DSP_VSYNC_X = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (i == 1) DSP_VSYNC_X = 1'b1;
            if (bus.ARVALID) bad++;
        end
        chk("t3_no_arvalid_while_afull", 32'(bad), 32'd0);
        bus.FIFO_AFULL = 1'b0;
        @(negedge ACLK);
        chk("t3_arvalid_after_afull", bus.ARVALID, 1'b1);
        wait_done(0);
        exp_frames++;

        // Slow ARREADY with FIFO_AFULL toggling
        rand_slave = 1;
        ar_hold = 10;
        DISPADDR = 29'h0100_0010;
        exp_addr_q.push_back(32'h0800_0080);
        exp_addr_q.push_back(32'h0800_0100);
        f0 = fifo_cnt;
        vs_pulse();
        wait_done(1);
        chk("t4_fifo_cnt", 32'(fifo_cnt - f0), 32'd32);
        exp_frames++;

        // Display switched off during beat 5 of burst 0
        rand_slave = 0;
        DISPADDR = 29'h0200_0000;
        exp_addr_q.push_back(32'h1000_0000);
        f0 = fifo_cnt;
        vs_pulse();
        wait_beats(5);
        DISPON = 1'b0;
        wait_done(0);
        chk("t5_fifo_cnt", 32'(fifo_cnt - f0), 32'd16);
        chk("t5_state_idle", dut.state_q, ST_IDLE);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (bus.ARVALID) bad++;
        end
        chk("t5_no_more_arvalid", 32'(bad), 32'd0);

        // Late frame: second VSYNC mid burst with a new base
        DISPON = 1'b1;
        repeat (2) @(negedge ACLK);
`ifdef DISP_VRAMRD_STAT_EN
        chk("t6_late_before", FRAME_LATE, 1'b0);
`endif
        exp_addr_q.push_back(32'h1000_0000);
        exp_addr_q.push_back(32'h1800_0000);
        exp_addr_q.push_back(32'h1800_0080);
        f0 = fifo_cnt;
        vs_pulse();
        wait_beats(3);
        DISPADDR = 29'h0300_0000;
        vs_pulse();
        wait_done(0);
        chk("t6_fifo_cnt", 32'(fifo_cnt - f0), 32'd48);
        chk("t6_state_end", dut.state_q, ST_WAIT_VS);
        exp_frames++;
`ifdef DISP_VRAMRD_STAT_EN
        chk("t6_frame_late", FRAME_LATE, 1'b1);
        chk("t6_frame_cnt", FRAME_CNT, 16'(exp_frames));
        @(negedge ACLK); STAT_CLR = 1'b1;
        @(negedge ACLK); STAT_CLR = 1'b0;
        chk("t6_late_cleared", FRAME_LATE, 1'b0);
`endif

        // Random frames, including a base that wraps the address space
        rand_slave = 1;
        for (int fr = 0; fr < 4; fr++) begin
            rb = (fr == 0) ? 29'h1FFF_FFF3 : 29'($urandom);
            DISPADDR = rb;
            exp_addr_q.push_back(exp_addr(rb, 0));
            exp_addr_q.push_back(exp_addr(rb, 1));
            f0 = fifo_cnt;
            vs_pulse();
            DISPADDR = 29'($urandom);
            wait_done(1);
            chk("t7_fifo_cnt", 32'(fifo_cnt - f0), 32'd32);
            exp_frames++;
        end
`ifdef DISP_VRAMRD_STAT_EN
        chk("t7_frame_cnt", FRAME_CNT, 16'(exp_frames));
`endif

        // Reset in the middle of a burst
        rand_slave = 0;
        DISPADDR = 29'h0040_0000;
        exp_addr_q.push_back(32'h0200_0000);
        vs_pulse();
        wait_beats(4);
        ARESETN = 1'b0;
        exp_addr_q.delete();
        @(negedge ACLK);
        chk("rst2_arvalid", bus.ARVALID, 1'b0);
        chk("rst2_rready", bus.RREADY, 1'b0);
        chk("rst2_fifo_wr", bus.FIFO_WR, 1'b0);
        chk("rst2_state", dut.state_q, ST_IDLE);
`ifdef DISP_VRAMRD_STAT_EN
        chk("rst2_frame_cnt", FRAME_CNT, 16'd0);
`endif
        ARESETN = 1'b1;
        repeat (3) @(negedge ACLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
